param_seq_controller: RTL and testbench
=======================================

Name: param_seq_controller

Overview:
Parametrised successor to the 10-bit processor controller. It owns its own step sequencer and no longer takes an external TIME input. It decodes an instruction word of configurable width and register count, and drives the datapath enables (register file, A/G registers, external/immediate bus, instruction register). It sits between the instruction source and the datapath, uses a RUN/DONE handshake, and flags illegal opcodes.

Parameters:
DATA_W, 10, instruction/datapath word width; must satisfy DATA_W >= 6 + 2*RW
NREG, 4, number of general registers (power of 2, >= 2); RW = $clog2(NREG) is a derived localparam

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
RUN  in  1  start request, sampled in IDLE and in the DONE cycle
INSTR  in  DATA_W  instruction word, valid during FETCH
IMM  out  DATA_W  immediate value, extended from the immediate field
Rin  out  RW  destination register index
Rout  out  RW  source register index
FN  out  4  ALU function code
ENW  out  1  register file write enable
ENR  out  1  register file read enable
Ain  out  1  A register load
Gin  out  1  G register load
Gout  out  1  G register drives the bus
Ext  out  1  external bus drive
INSTin  out  1  instruction register load
enIMM  out  1  immediate drives the bus
DONE  out  1  one-cycle pulse on the final step
BUSY  out  1  high in any state other than IDLE
ERR  out  1  one-cycle pulse on an illegal opcode

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high. On reset the state is IDLE, the latched fields are 0, and every output is 0.
- Outputs are Moore: a function of the state register and the latched fields only. Every enable not listed for a step is 0.
- States: IDLE, FETCH, EX1, EX2, EX3.
- IDLE -> FETCH when RUN=1.
- FETCH: Ext=1, INSTin=1. At the FETCH clock edge, latch the fields from INSTR, then go to EX1.
- Instruction format, with MSB = DATA_W-1:
  - IMMF = INSTR[MSB]; SUBSEL = INSTR[MSB-1].
  - RX = next RW bits below SUBSEL; RY = next RW bits below RX.
  - Register form: FN = INSTR[3:0].
  - Immediate form (IMMF=1): immediate field = INSTR[MSB-2-RW:0]; FN = 4'b1101 if SUBSEL=1, else 4'b1100; RY is ignored.
- FN and IMM are held from the FETCH latch until the next FETCH latch. IMM = 0 for register-form instructions.
- Step sequences by FN:
  - LOAD 0000: EX1 Ext, ENW, Rin=RX, DONE.
  - COPY 0001: EX1 ENR, Rout=RY, ENW, Rin=RX, DONE.
  - Binary ops (ADD 0010, SUB 0011, AND 0110, OR 0111, XOR 1000, LSL 1001, LSR 1010, ASR 1011):
    - EX1: Rout=RX, ENR, Ain.
    - EX2: Rout=RY, ENR, Gin.
    - EX3: Gout, ENW, Rin=RX, DONE.
  - Unary ops (INV 0100, FLP 0101):
    - EX1: Rout=RY, ENR, Ain.
    - EX2: Gin.
    - EX3: Gout, ENW, Rin=RX, DONE.
  - ADDI 1100 / SUBI 1101:
    - EX1: enIMM, Ain.
    - EX2: Rout=RX, ENR, Gin.
    - EX3: Gout, ENW, Rin=RX, DONE.
  - Illegal 1110/1111 (register form): EX1 asserts ERR and DONE only, with no datapath enables.
- Transition after the DONE step: to FETCH if RUN=1 (back-to-back, no IDLE cycle), otherwise to IDLE.
- RUN is ignored in FETCH and in EX steps that are not DONE steps.
- Latency from FETCH to DONE (inclusive): LOAD/COPY/illegal 2 cycles; all others 4 cycles.
- Reset mid-operation: outputs clear immediately and asynchronously; no partial write completes after RST.
- Rin and Rout hold their last value when ENW/ENR are 0; they are don't-care for the bench.

Optional Feature:
IMM_SEXT_EN
- Defined: IMM is sign-extended from the MSB of the immediate field.
- Undefined: IMM is zero-extended.

Decomposition:
- Package param_ctrl_pkg:
  - op_e, a 4-bit enum of the 14 opcodes plus ILL_A/ILL_B
  - state_e enum
  - localparams FN_ADDI and FN_SUBI
- Sub-module param_ctrl_decode: combinational field extraction and extension (INSTR -> RX, RY, FN, IMM), parametrised on DATA_W and NREG.

Test Plan:
1. DATA_W=10, ADD R1,R2: INSTR=0x062 with a RUN pulse -> FETCH Ext=INSTin=1; EX1 Rout=1 ENR Ain; EX2 Rout=2 ENR Gin; EX3 Gout ENW Rin=1 DONE; FN=0x2; BUSY high for 4 cycles.
2. SUBI R3,#45: INSTR=0x3ED -> FN=0xD; IMM=0x02D without IMM_SEXT_EN, 0x3ED with it; EX1 enIMM Ain; EX3 Rin=3 ENW DONE.
3. LOAD R2: INSTR=0x080 -> EX1 Ext ENW Rin=2 DONE; back to IDLE after 2 cycles with RUN=0.
4. Illegal: INSTR=0x00E -> EX1 ERR=1 DONE=1, all enables 0, then IDLE.
5. Back-to-back: RUN held at 1, COPY R0<-R3 (0x031) then INV R1<-R2 (0x064) -> DONE cycle immediately followed by FETCH; second op finishes 4 cycles later.
6. Reset mid-op: assert RST in EX2 of an ADD -> all outputs 0 before the next edge, state IDLE, no ENW; repeat with DATA_W=12, NREG=8 and INSTR=0x5C2 (ADD R3,R4) -> Rout=3 then 4, Rin=3.

Source files
------------

// File: rtl/param_ctrl_pkg.sv
// Shared opcode/state types and helpers for the parametrised sequencing controller.
package param_ctrl_pkg;

    // ALU function codes as carried on FN
    typedef enum logic [3:0] {
        LOAD  = 4'b0000,
        COPY  = 4'b0001,
        ADD   = 4'b0010,
        SUB   = 4'b0011,
        INV   = 4'b0100,
        FLP   = 4'b0101,
        AND   = 4'b0110,
        OR    = 4'b0111,
        XOR   = 4'b1000,
        LSL   = 4'b1001,
        LSR   = 4'b1010,
        ASR   = 4'b1011,
        ADDI  = 4'b1100,
        SUBI  = 4'b1101,
        ILL_A = 4'b1110,
        ILL_B = 4'b1111
    } op_e;

    // Step sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EX1   = 3'd2,
        EX2   = 3'd3,
        EX3   = 3'd4
    } state_e;

    localparam logic [3:0] FN_ADDI = 4'b1100;
    localparam logic [3:0] FN_SUBI = 4'b1101;

    // Opcodes that complete in EX1 rather than EX3
    function automatic logic is_short_op(input op_e op);
        return (op == LOAD) || (op == COPY) || (op == ILL_A) || (op == ILL_B);
    endfunction

endpackage

// File: rtl/param_ctrl_decode.sv
// Instruction field extraction: INSTR -> RX, RY, FN, IMM.
// Optional macro IMM_SEXT_EN: sign-extend the immediate field (zero-extend otherwise).
module param_ctrl_decode
    import param_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned NREG   = 4,
    localparam int unsigned RW    = $clog2(NREG)
) (
    input  logic [DATA_W-1:0] instr,
    output logic [RW-1:0]     rx,
    output logic [RW-1:0]     ry,
    output logic [3:0]        fn,
    output logic [DATA_W-1:0] imm
);

    localparam int unsigned MSB   = DATA_W - 1;
    localparam int unsigned IMM_W = DATA_W - 2 - RW;

    logic             immf;
    logic             subsel;
    logic [IMM_W-1:0] imm_fld;

    assign immf    = instr[MSB];
    assign subsel  = instr[MSB-1];
    assign rx      = instr[MSB-2 -: RW];
    assign ry      = instr[MSB-2-RW -: RW];
    assign imm_fld = instr[IMM_W-1:0];

    // Function code and extended immediate; register form carries no immediate
    always_comb begin
        fn  = instr[3:0];
        imm = '0;
        if (immf) begin
            fn = subsel ? FN_SUBI : FN_ADDI;
`ifdef IMM_SEXT_EN
            imm = {{(DATA_W-IMM_W){imm_fld[IMM_W-1]}}, imm_fld};
`else
            imm = DATA_W'(imm_fld);
`endif
        end
    end

endmodule

// File: rtl/param_seq_controller.sv
// Parametrised processor controller with internal step sequencer and RUN/DONE handshake.
// Optional macro IMM_SEXT_EN (in param_ctrl_decode): sign-extended immediates.
module param_seq_controller
    import param_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned NREG   = 4,
    localparam int unsigned RW    = $clog2(NREG)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RUN,
    input  logic [DATA_W-1:0] INSTR,
    output logic [DATA_W-1:0] IMM,
    output logic [RW-1:0]     Rin,
    output logic [RW-1:0]     Rout,
    output logic [3:0]        FN,
    output logic              ENW,
    output logic              ENR,
    output logic              Ain,
    output logic              Gin,
    output logic              Gout,
    output logic              Ext,
    output logic              INSTin,
    output logic              enIMM,
    output logic              DONE,
    output logic              BUSY,
    output logic              ERR
);

    state_e            state_q, state_d;
    op_e               fn_q;
    logic [DATA_W-1:0] imm_q;
    logic [RW-1:0]     rx_q, ry_q;

    logic [RW-1:0]     dec_rx, dec_ry;
    logic [3:0]        dec_fn;
    logic [DATA_W-1:0] dec_imm;

    param_ctrl_decode #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_decode (
        .instr (INSTR),
        .rx    (dec_rx),
        .ry    (dec_ry),
        .fn    (dec_fn),
        .imm   (dec_imm)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Instruction fields captured at the FETCH edge and held until the next fetch
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fn_q  <= LOAD;
            imm_q <= '0;
            rx_q  <= '0;
            ry_q  <= '0;
        end else if (state_q == FETCH) begin
            fn_q  <= op_e'(dec_fn);
            imm_q <= dec_imm;
            rx_q  <= dec_rx;
            ry_q  <= dec_ry;
        end
    end

    // Next state: short ops finish in EX1, the rest in EX3; RUN on DONE chains a fetch
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (RUN) state_d = FETCH;
            FETCH:   state_d = EX1;
            EX1:     begin
                if (is_short_op(fn_q)) state_d = RUN ? FETCH : IDLE;
                else                   state_d = EX2;
            end
            EX2:     state_d = EX3;
            EX3:     state_d = RUN ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs from state and latched fields
    always_comb begin
        Ext    = 1'b0;
        INSTin = 1'b0;
        ENW    = 1'b0;
        ENR    = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        Gout   = 1'b0;
        enIMM  = 1'b0;
        DONE   = 1'b0;
        ERR    = 1'b0;
        Rin    = rx_q;
        Rout   = rx_q;
        BUSY   = (state_q != IDLE);
        case (state_q)
            FETCH: begin
                Ext    = 1'b1;
                INSTin = 1'b1;
            end
            EX1: begin
                case (fn_q)
                    LOAD: begin
                        Ext  = 1'b1;
                        ENW  = 1'b1;
                        DONE = 1'b1;
                    end
                    COPY: begin
                        ENR  = 1'b1;
                        Rout = ry_q;
                        ENW  = 1'b1;
                        DONE = 1'b1;
                    end
                    ADD, SUB, AND, OR, XOR, LSL, LSR, ASR: begin
                        ENR = 1'b1;
                        Ain = 1'b1;
                    end
                    INV, FLP: begin
                        Rout = ry_q;
                        ENR  = 1'b1;
                        Ain  = 1'b1;
                    end
                    ADDI, SUBI: begin
                        enIMM = 1'b1;
                        Ain   = 1'b1;
                    end
                    default: begin
                        ERR  = 1'b1;
                        DONE = 1'b1;
                    end
                endcase
            end
            EX2: begin
                case (fn_q)
                    ADD, SUB, AND, OR, XOR, LSL, LSR, ASR: begin
                        Rout = ry_q;
                        ENR  = 1'b1;
                        Gin  = 1'b1;
                    end
                    INV, FLP: Gin = 1'b1;
                    ADDI, SUBI: begin
                        ENR = 1'b1;
                        Gin = 1'b1;
                    end
                    default: ;
                endcase
            end
            EX3: begin
                Gout = 1'b1;
                ENW  = 1'b1;
                DONE = 1'b1;
            end
            default: ;
        endcase
    end

    assign FN  = fn_q;
    assign IMM = imm_q;

endmodule

// File: tb/tb_param_seq_controller.sv
// Bench for param_seq_controller: step-plan model plus directed pinned checks.
module tb_param_seq_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-configuration instance (DATA_W=10, NREG=4)
    logic       rst = 1'b1, run = 1'b0;
    logic [9:0] instr = '0;
    logic [9:0] IMM;
    logic [1:0] Rin, Rout;
    logic [3:0] FN;
    logic ENW, ENR, Ain, Gin, Gout, Ext, INSTin, enIMM, DONE, BUSY, ERR;

    // Wide instance (DATA_W=12, NREG=8)
    logic        rst_b = 1'b1, run_b = 1'b0;
    logic [11:0] instr_b = '0;
    logic [11:0] IMM_b;
    logic [2:0]  Rin_b, Rout_b;
    logic [3:0]  FN_b;
    logic ENW_b, ENR_b, Ain_b, Gin_b, Gout_b, Ext_b, INSTin_b, enIMM_b, DONE_b, BUSY_b, ERR_b;

    param_seq_controller #(.DATA_W(10), .NREG(4)) u_dut (
        .CLK(clk), .RST(rst), .RUN(run), .INSTR(instr), .IMM(IMM), .Rin(Rin), .Rout(Rout),
        .FN(FN), .ENW(ENW), .ENR(ENR), .Ain(Ain), .Gin(Gin), .Gout(Gout), .Ext(Ext),
        .INSTin(INSTin), .enIMM(enIMM), .DONE(DONE), .BUSY(BUSY), .ERR(ERR)
    );

    param_seq_controller #(.DATA_W(12), .NREG(8)) u_dut_b (
        .CLK(clk), .RST(rst_b), .RUN(run_b), .INSTR(instr_b), .IMM(IMM_b), .Rin(Rin_b),
        .Rout(Rout_b), .FN(FN_b), .ENW(ENW_b), .ENR(ENR_b), .Ain(Ain_b), .Gin(Gin_b),
        .Gout(Gout_b), .Ext(Ext_b), .INSTin(INSTin_b), .enIMM(enIMM_b), .DONE(DONE_b),
        .BUSY(BUSY_b), .ERR(ERR_b)
    );

    localparam logic [10:0] B_EXT   = 11'h400;
    localparam logic [10:0] B_INSTIN= 11'h200;
    localparam logic [10:0] B_ENW   = 11'h100;
    localparam logic [10:0] B_ENR   = 11'h080;
    localparam logic [10:0] B_AIN   = 11'h040;
    localparam logic [10:0] B_GIN   = 11'h020;
    localparam logic [10:0] B_GOUT  = 11'h010;
    localparam logic [10:0] B_ENIMM = 11'h008;
    localparam logic [10:0] B_DONE  = 11'h004;
    localparam logic [10:0] B_ERR   = 11'h002;
    localparam logic [10:0] B_BUSY  = 11'h001;

`ifdef IMM_SEXT_EN
    localparam logic [9:0] EXP_SUBI_IMM = 10'h3ED;
`else
    localparam logic [9:0] EXP_SUBI_IMM = 10'h02D;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    function automatic logic [10:0] vA();
        return {Ext, INSTin, ENW, ENR, Ain, Gin, Gout, enIMM, DONE, ERR, BUSY};
    endfunction

    function automatic logic [10:0] vB();
        return {Ext_b, INSTin_b, ENW_b, ENR_b, Ain_b, Gin_b, Gout_b, enIMM_b, DONE_b, ERR_b, BUSY_b};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: queue of expected per-cycle output vectors ----------------
    typedef struct packed {
        logic [10:0] vec;
        logic        fetch;
        logic [1:0]  rin;
        logic [1:0]  rout;
    } step_t;

    step_t      plan[$];
    step_t      exp_s;
    logic [3:0] m_fn  = '0;
    logic [9:0] m_imm = '0;

    task automatic put(input logic [10:0] v, input logic [1:0] ri, input logic [1:0] ro);
        plan.push_back('{vec: v | B_BUSY, fetch: 1'b0, rin: ri, rout: ro});
    endtask

    task automatic put_fetch();
        plan.push_back('{vec: B_EXT | B_INSTIN | B_BUSY, fetch: 1'b1, rin: 2'd0, rout: 2'd0});
    endtask

    // Expand a fetched word into the cycles it must produce
    task automatic expand(input logic [9:0] w);
        logic [1:0] rx, ry;
        rx = w[7:6];
        ry = w[5:4];
        if (w[9]) begin
            m_fn = w[8] ? 4'hD : 4'hC;
`ifdef IMM_SEXT_EN
            m_imm = {{4{w[5]}}, w[5:0]};
`else
            m_imm = {4'b0000, w[5:0]};
`endif
        end else begin
            m_fn  = w[3:0];
            m_imm = '0;
        end
        case (m_fn)
            4'h0: put(B_EXT | B_ENW | B_DONE, rx, rx);
            4'h1: put(B_ENR | B_ENW | B_DONE, rx, ry);
            4'h2, 4'h3, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB: begin
                put(B_ENR | B_AIN, rx, rx);
                put(B_ENR | B_GIN, rx, ry);
                put(B_GOUT | B_ENW | B_DONE, rx, rx);
            end
            4'h4, 4'h5: begin
                put(B_ENR | B_AIN, rx, ry);
                put(B_GIN, rx, rx);
                put(B_GOUT | B_ENW | B_DONE, rx, rx);
            end
            4'hC, 4'hD: begin
                put(B_ENIMM | B_AIN, rx, rx);
                put(B_ENR | B_GIN, rx, rx);
                put(B_GOUT | B_ENW | B_DONE, rx, rx);
            end
            default: put(B_ERR | B_DONE, rx, rx);
        endcase
    endtask

    // Model advance on each edge; reset empties the plan immediately
    always @(posedge clk or posedge rst) begin
        step_t cur;
        if (rst) begin
            plan.delete();
            m_fn  = '0;
            m_imm = '0;
        end else if (plan.size() == 0) begin
            if (run) put_fetch();
        end else begin
            cur = plan.pop_front();
            if (cur.fetch) expand(instr);
            else if ((cur.vec & B_DONE) != 0 && run) put_fetch();
        end
    end

    // Compare default instance against the model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            exp_s = (plan.size() != 0) ? plan[0] : '0;
            chk("m_vec", 32'(vA()), 32'(exp_s.vec));
            chk("m_fn",  32'(FN),   32'(m_fn));
            chk("m_imm", 32'(IMM),  32'(m_imm));
            if ((exp_s.vec & B_ENW) != 0) chk("m_rin",  32'(Rin),  32'(exp_s.rin));
            if ((exp_s.vec & B_ENR) != 0) chk("m_rout", 32'(Rout), 32'(exp_s.rout));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [9:0] prog [7];

    initial begin
        prog = '{10'h0A7, 10'h01A, 10'h0F5, 10'h2C5, 10'h31F, 10'h2E0, 10'h00F};
        repeat (2) cyc();
        chk("rst_vec",   32'(vA()), 32'd0);
        chk("rst_fn",    32'(FN),   32'd0);
        chk("rst_imm",   32'(IMM),  32'd0);
        chk("rst_vec_b", 32'(vB()), 32'd0);
        rst = 1'b0; rst_b = 1'b0; chk_en = 1'b1;
        cyc();

        // ADD R1,R2
        instr = 10'h062; run = 1'b1; cyc(); run = 1'b0;
        chk("t1_fetch", 32'(vA()), 32'(B_EXT | B_INSTIN | B_BUSY));
        cyc();
        chk("t1_ex1", 32'(vA()), 32'(B_ENR | B_AIN | B_BUSY));
        chk("t1_ex1_rout", 32'(Rout), 32'd1);
        cyc();
        chk("t1_ex2", 32'(vA()), 32'(B_ENR | B_GIN | B_BUSY));
        chk("t1_ex2_rout", 32'(Rout), 32'd2);
        chk("t1_fn", 32'(FN), 32'h2);
        cyc();
        chk("t1_ex3", 32'(vA()), 32'(B_GOUT | B_ENW | B_DONE | B_BUSY));
        chk("t1_ex3_rin", 32'(Rin), 32'd1);
        cyc();
        chk("t1_idle", 32'(vA()), 32'd0);

        // SUBI R3,#45
        instr = 10'h3ED; run = 1'b1; cyc(); run = 1'b0;
        cyc();
        chk("t2_ex1", 32'(vA()), 32'(B_ENIMM | B_AIN | B_BUSY));
        chk("t2_fn",  32'(FN),   32'hD);
        chk("t2_imm", 32'(IMM),  32'(EXP_SUBI_IMM));
        cyc();
        chk("t2_ex2_rout", 32'(Rout), 32'd3);
        cyc();
        chk("t2_ex3", 32'(vA()), 32'(B_GOUT | B_ENW | B_DONE | B_BUSY));
        chk("t2_ex3_rin", 32'(Rin), 32'd3);
        cyc();

        // LOAD R2
        instr = 10'h080; run = 1'b1; cyc(); run = 1'b0;
        cyc();
        chk("t3_ex1", 32'(vA()), 32'(B_EXT | B_ENW | B_DONE | B_BUSY));
        chk("t3_rin", 32'(Rin), 32'd2);
        chk("t3_imm", 32'(IMM), 32'd0);
        cyc();
        chk("t3_idle", 32'(vA()), 32'd0);

        // Illegal 1110
        instr = 10'h00E; run = 1'b1; cyc(); run = 1'b0;
        cyc();
        chk("t4_ex1", 32'(vA()), 32'(B_ERR | B_DONE | B_BUSY));
        cyc();
        chk("t4_idle", 32'(vA()), 32'd0);

        // Back-to-back COPY R0<-R3 then INV R1<-R2
        instr = 10'h031; run = 1'b1; cyc();
        cyc();
        chk("t5_copy", 32'(vA()), 32'(B_ENR | B_ENW | B_DONE | B_BUSY));
        chk("t5_copy_rout", 32'(Rout), 32'd3);
        chk("t5_copy_rin",  32'(Rin),  32'd0);
        instr = 10'h064;
        cyc();
        chk("t5_refetch", 32'(vA()), 32'(B_EXT | B_INSTIN | B_BUSY));
        run = 1'b0;
        cyc();
        chk("t5_inv_ex1", 32'(vA()), 32'(B_ENR | B_AIN | B_BUSY));
        chk("t5_inv_rout", 32'(Rout), 32'd2);
        cyc();
        chk("t5_inv_ex2", 32'(vA()), 32'(B_GIN | B_BUSY));
        cyc();
        chk("t5_inv_ex3", 32'(vA()), 32'(B_GOUT | B_ENW | B_DONE | B_BUSY));
        chk("t5_inv_rin", 32'(Rin), 32'd1);
        cyc();

        // Reset in EX2 of ADD
        instr = 10'h062; run = 1'b1; cyc(); run = 1'b0;
        cyc(); cyc();
        chk("t6_ex2", 32'(vA()), 32'(B_ENR | B_GIN | B_BUSY));
        rst = 1'b1; #1;
        chk("t6_async_vec", 32'(vA()), 32'd0);
        chk("t6_async_fn",  32'(FN),   32'd0);
        chk("t6_async_rin", 32'(Rin),  32'd0);
        cyc();
        chk("t6_held", 32'(vA()), 32'd0);
        rst = 1'b0;
        cyc();
        chk("t6_no_write", 32'(vA()), 32'd0);

        // Mixed program, checked by the model
        foreach (prog[i]) begin
            instr = prog[i]; run = 1'b1; cyc(); run = 1'b0;
            repeat (5) cyc();
        end
        chk("fn_hold", 32'(FN), 32'hF);

        // Wide instance: ADD R3,R4
        instr_b = 12'h5C2; run_b = 1'b1; cyc(); run_b = 1'b0;
        chk("b_fetch", 32'(vB()), 32'(B_EXT | B_INSTIN | B_BUSY));
        cyc();
        chk("b_ex1", 32'(vB()), 32'(B_ENR | B_AIN | B_BUSY));
        chk("b_ex1_rout", 32'(Rout_b), 32'd3);
        cyc();
        chk("b_ex2", 32'(vB()), 32'(B_ENR | B_GIN | B_BUSY));
        chk("b_ex2_rout", 32'(Rout_b), 32'd4);
        chk("b_fn",  32'(FN_b),  32'h2);
        chk("b_imm", 32'(IMM_b), 32'd0);
        cyc();
        chk("b_ex3", 32'(vB()), 32'(B_GOUT | B_ENW | B_DONE | B_BUSY));
        chk("b_ex3_rin", 32'(Rin_b), 32'd3);
        cyc();
        chk("b_idle", 32'(vB()), 32'd0);

        // Wide instance: reset in EX2
        run_b = 1'b1; cyc(); run_b = 1'b0;
        cyc(); cyc();
        rst_b = 1'b1; #1;
        chk("b_async_vec",  32'(vB()),   32'd0);
        chk("b_async_rout", 32'(Rout_b), 32'd0);
        chk("b_async_fn",   32'(FN_b),   32'd0);
        cyc();
        rst_b = 1'b0;
        cyc();
        chk("b_no_write", 32'(vB()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
